i2c_slave_regfile: RTL and testbench



---
 rtl/i2c_pkg.sv | 20 ++
 rtl/i2c_sync_edge.sv | 34 +++
 rtl/i2c_slave_regfile.sv | 181 ++++++++++++++++++
 tb/tb_i2c_slave_regfile.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared I2C transfer direction and target state types
package i2c_pkg;

  typedef enum logic {
    I2C_WRITE = 1'b0,
    I2C_READ  = 1'b1
  } i2c_op_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_PTR,
    ST_WR_DATA,
    ST_WR_ACK,
    ST_RD_DATA,
    ST_RD_ACK
  } i2c_slave_state_t;

endpackage

// File: rtl/i2c_sync_edge.sv
// rtl/i2c_sync_edge.sv - 2-flop synchronizer with SCL edge and START/STOP detection
module i2c_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic scl_raw,
  input  logic sda_raw,
  output logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start,
  output logic stop
);

  // [1] is the synced value, [2] its previous sample; reset to the idle-high bus level
  logic [2:0] scl_q;
  logic [2:0] sda_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_q <= '1;
      sda_q <= '1;
    end else begin
      scl_q <= {scl_q[1:0], scl_raw};
      sda_q <= {sda_q[1:0], sda_raw};
    end
  end

  assign sda      = sda_q[1];
  assign scl_rise = scl_q[1] & ~scl_q[2];
  assign scl_fall = ~scl_q[1] & scl_q[2];
  assign start    = scl_q[1] & scl_q[2] & ~sda_q[1] & sda_q[2];
  assign stop     = scl_q[1] & scl_q[2] & sda_q[1] & ~sda_q[2];

endmodule

// File: rtl/i2c_slave_regfile.sv
// rtl/i2c_slave_regfile.sv - I2C target with an auto-incrementing byte register file
module i2c_slave_regfile #(
  parameter int                        I2C_ADDR_WIDTH = 7,
  parameter int                        I2C_DATA_WIDTH = 8,
  parameter logic [I2C_ADDR_WIDTH-1:0] SLAVE_ADDR     = 7'h22,
  parameter int                        MEM_DEPTH      = 16
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          scl_i,
  input  logic                          sda_i,
  output logic                          scl_o,
  output logic                          sda_o,
  output logic                          busy_o,
  output logic                          wr_strobe_o,
  output logic [$clog2(MEM_DEPTH)-1:0]  wr_addr_o,
  output logic [I2C_DATA_WIDTH-1:0]     wr_data_o
);
  import i2c_pkg::*;

  localparam int AW = $clog2(MEM_DEPTH);
  localparam int DW = I2C_DATA_WIDTH;
  localparam int CW = $clog2(DW + 1);

  logic sda_s, scl_rise, scl_fall, start, stop;

  i2c_sync_edge u_sync (
    .clk      (clk_i),
    .rst      (rst_i),
    .scl_raw  (scl_i),
    .sda_raw  (sda_i),
    .sda      (sda_s),
    .scl_rise (scl_rise),
    .scl_fall (scl_fall),
    .start    (start),
    .stop     (stop)
  );

  i2c_slave_state_t  state;
  i2c_op_t           rw;
  logic [CW-1:0]     bit_cnt;
  logic [DW-1:0]     shreg;
  logic [AW-1:0]     ptr;
  logic              ack_on;
  logic              got_ack;
  logic [DW-1:0]     mem [MEM_DEPTH];

  logic [DW-1:0]     byte_in;
  logic              last_bit;

  assign byte_in  = {shreg[DW-2:0], sda_s};
  assign last_bit = (bit_cnt == CW'(DW - 1));
  assign scl_o    = 1'b1;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= ST_IDLE;
      rw          <= I2C_WRITE;
      bit_cnt     <= '0;
      shreg       <= '0;
      ptr         <= '0;
      ack_on      <= 1'b0;
      got_ack     <= 1'b0;
      sda_o       <= 1'b1;
      busy_o      <= 1'b0;
      wr_strobe_o <= 1'b0;
      wr_addr_o   <= '0;
      wr_data_o   <= '0;
      for (int i = 0; i < MEM_DEPTH; i++) mem[i] <= '0;
    end else begin
      wr_strobe_o <= 1'b0;
      if (stop) begin
        state  <= ST_IDLE;
        sda_o  <= 1'b1;
        busy_o <= 1'b0;
      end else if (start) begin
        state   <= ST_ADDR;
        bit_cnt <= '0;
        ack_on  <= 1'b0;
      end else begin
        case (state)
          ST_ADDR: if (scl_rise) begin
            shreg   <= byte_in;
            bit_cnt <= bit_cnt + CW'(1);
            if (last_bit) begin
              if (byte_in[DW-1 -: I2C_ADDR_WIDTH] == SLAVE_ADDR) begin
                state  <= ST_ADDR_ACK;
                busy_o <= 1'b1;
                rw     <= i2c_op_t'(byte_in[0]);
                ack_on <= 1'b0;
              end else begin
                state  <= ST_IDLE;
                sda_o  <= 1'b1;
                busy_o <= 1'b0;
              end
            end
          end

          // first fall pulls sda for the ACK slot, second fall ends it
          ST_ADDR_ACK, ST_WR_ACK: if (scl_fall) begin
            if (!ack_on) begin
              sda_o  <= 1'b0;
              ack_on <= 1'b1;
            end else begin
              ack_on  <= 1'b0;
              bit_cnt <= '0;
              if (state == ST_WR_ACK) begin
                sda_o <= 1'b1;
                state <= ST_WR_DATA;
              end else if (rw == I2C_WRITE) begin
                sda_o <= 1'b1;
                state <= ST_PTR;
              end else begin
                shreg   <= mem[ptr] << 1;
                sda_o   <= mem[ptr][DW-1];
                bit_cnt <= CW'(1);
                state   <= ST_RD_DATA;
              end
            end
          end

          ST_PTR: if (scl_rise) begin
            shreg   <= byte_in;
            bit_cnt <= bit_cnt + CW'(1);
            if (last_bit) begin
              ptr    <= byte_in[AW-1:0];
              ack_on <= 1'b0;
              state  <= ST_WR_ACK;
            end
          end

          ST_WR_DATA: if (scl_rise) begin
            shreg   <= byte_in;
            bit_cnt <= bit_cnt + CW'(1);
            if (last_bit) begin
              mem[ptr]    <= byte_in;
              wr_strobe_o <= 1'b1;
              wr_addr_o   <= ptr;
              wr_data_o   <= byte_in;
              ptr         <= ptr + AW'(1);
              ack_on      <= 1'b0;
              state       <= ST_WR_ACK;
            end
          end

          ST_RD_DATA: if (scl_fall) begin
            if (bit_cnt == CW'(DW)) begin
              sda_o   <= 1'b1;
              ptr     <= ptr + AW'(1);
              got_ack <= 1'b0;
              state   <= ST_RD_ACK;
            end else begin
              sda_o   <= shreg[DW-1];
              shreg   <= shreg << 1;
              bit_cnt <= bit_cnt + CW'(1);
            end
          end

          ST_RD_ACK: begin
            if (scl_rise) begin
              if (sda_s) begin
                state  <= ST_IDLE;
                busy_o <= 1'b0;
              end else begin
                got_ack <= 1'b1;
              end
            end else if (scl_fall && got_ack) begin
              shreg   <= mem[ptr] << 1;
              sda_o   <= mem[ptr][DW-1];
              bit_cnt <= CW'(1);
              state   <= ST_RD_DATA;
            end
          end

          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_slave_regfile.sv
// tb/tb_i2c_slave_regfile.sv - bus-level bench for i2c_slave_regfile against a register-array model
module tb_i2c_slave_regfile;

  localparam int         Q     = 5;
  localparam int         DEPTH = 16;
  localparam logic [6:0] SADDR = 7'h22;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic       scl_o, sda_o, busy_o, wr_strobe_o;
  logic [3:0] wr_addr_o;
  logic [7:0] wr_data_o;

  wire sda_line = sda_m & sda_o;
  wire scl_line = scl_m & scl_o;

  int checks = 0;
  int errors = 0;

  logic [7:0]  model_mem [DEPTH];
  int          model_ptr = 0;
  logic [7:0]  wq[$];
  logic [11:0] strobe_log [1024];
  int          strobe_n  = 0;
  int          sda_low_n = 0;
  int          busy_n    = 0;

  always #5 clk_i = ~clk_i;

  i2c_slave_regfile dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .scl_i       (scl_line),
    .sda_i       (sda_line),
    .scl_o       (scl_o),
    .sda_o       (sda_o),
    .busy_o      (busy_o),
    .wr_strobe_o (wr_strobe_o),
    .wr_addr_o   (wr_addr_o),
    .wr_data_o   (wr_data_o)
  );

  always @(negedge clk_i) begin
    if (wr_strobe_o && strobe_n < 1024) begin
      strobe_log[strobe_n] = {wr_addr_o, wr_data_o};
      strobe_n = strobe_n + 1;
    end
    if (sda_o === 1'b0) sda_low_n = sda_low_n + 1;
    if (busy_o === 1'b1) busy_n = busy_n + 1;
  end

  task automatic hq();
    repeat (Q) @(posedge clk_i);
    #1;
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; hq();
    scl_m = 1'b1; hq();
    sda_m = 1'b0; hq();
    scl_m = 1'b0; hq();
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; hq();
    scl_m = 1'b1; hq();
    sda_m = 1'b1; hq(); hq();
  endtask

  task automatic send_bits(input int n, input logic [7:0] b);
    logic [7:0] v;
    v = b;
    for (int i = 0; i < n; i++) begin
      sda_m = v[7]; v = v << 1;
      hq(); scl_m = 1'b1; hq(); hq(); scl_m = 1'b0; hq();
    end
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    send_bits(8, b);
    sda_m = 1'b1; hq();
    scl_m = 1'b1; hq();
    ack = sda_line; hq();
    scl_m = 1'b0; hq();
  endtask

  task automatic recv_byte(output logic [7:0] d, input logic nack);
    d = '0;
    for (int i = 0; i < 8; i++) begin
      sda_m = 1'b1; hq();
      scl_m = 1'b1; hq();
      d = {d[6:0], sda_line}; hq();
      scl_m = 1'b0; hq();
    end
    sda_m = nack; hq();
    scl_m = 1'b1; hq(); hq();
    scl_m = 1'b0; hq();
  endtask

  // Write transaction of pointer byte followed by wq; expectations come from the array model
  task automatic do_write(input logic [7:0] ptr_byte);
    logic        a;
    int          s0;
    logic [11:0] exp;
    s0 = strobe_n;
    i2c_start();
    send_byte({SADDR, 1'b0}, a);
    checks++;
    if (a !== 1'b0) begin errors++; $display("FAIL wr_addr_ack: got %b expected 0", a); end
    checks++;
    if (busy_o !== 1'b1) begin errors++; $display("FAIL wr_busy: got %b expected 1", busy_o); end
    send_byte(ptr_byte, a);
    checks++;
    if (a !== 1'b0) begin errors++; $display("FAIL wr_ptr_ack: got %b expected 0", a); end
    model_ptr = int'(ptr_byte) % DEPTH;
    foreach (wq[i]) begin
      send_byte(wq[i], a);
      checks++;
      if (a !== 1'b0) begin errors++; $display("FAIL wr_data_ack[%0d]: got %b expected 0", i, a); end
      exp = {4'(model_ptr), wq[i]};
      model_mem[model_ptr] = wq[i];
      model_ptr = (model_ptr + 1) % DEPTH;
      checks++;
      if (strobe_n <= s0 + i) begin
        errors++; $display("FAIL wr_strobe_missing[%0d]: got %0d strobes expected %0d", i, strobe_n - s0, i + 1);
      end else if (strobe_log[s0 + i] !== exp) begin
        errors++; $display("FAIL wr_strobe[%0d]: got %h expected %h", i, strobe_log[s0 + i], exp);
      end
    end
    i2c_stop();
    checks++;
    if (busy_o !== 1'b0) begin errors++; $display("FAIL wr_busy_after_stop: got %b expected 0", busy_o); end
    checks++;
    if (strobe_n - s0 != wq.size()) begin
      errors++; $display("FAIL wr_strobe_count: got %0d expected %0d", strobe_n - s0, wq.size());
    end
  endtask

  // Optional pointer set, then (repeated) START read of n bytes, NACK on the last
  task automatic do_read(input logic [7:0] ptr_byte, input int n, input bit set_ptr);
    logic       a;
    logic [7:0] d;
    logic [7:0] exp;
    if (set_ptr) begin
      i2c_start();
      send_byte({SADDR, 1'b0}, a);
      checks++;
      if (a !== 1'b0) begin errors++; $display("FAIL rd_waddr_ack: got %b expected 0", a); end
      send_byte(ptr_byte, a);
      checks++;
      if (a !== 1'b0) begin errors++; $display("FAIL rd_ptr_ack: got %b expected 0", a); end
      model_ptr = int'(ptr_byte) % DEPTH;
    end
    i2c_start();
    send_byte({SADDR, 1'b1}, a);
    checks++;
    if (a !== 1'b0) begin errors++; $display("FAIL rd_addr_ack: got %b expected 0", a); end
    for (int i = 0; i < n; i++) begin
      recv_byte(d, (i == n - 1));
      exp = model_mem[model_ptr];
      model_ptr = (model_ptr + 1) % DEPTH;
      checks++;
      if (d !== exp) begin errors++; $display("FAIL rd_data[%0d]: got %h expected %h", i, d, exp); end
    end
    checks++;
    if (busy_o !== 1'b0) begin errors++; $display("FAIL rd_busy_after_nack: got %b expected 0", busy_o); end
    i2c_stop();
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk_i);
    #1;
    checks++;
    if (sda_o !== 1'b1) begin errors++; $display("FAIL rst_sda: got %b expected 1", sda_o); end
    checks++;
    if (scl_o !== 1'b1) begin errors++; $display("FAIL rst_scl: got %b expected 1", scl_o); end
    checks++;
    if (busy_o !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", busy_o); end
    checks++;
    if (wr_strobe_o !== 1'b0) begin errors++; $display("FAIL rst_strobe: got %b expected 0", wr_strobe_o); end
    checks++;
    if ({wr_addr_o, wr_data_o} !== 12'h000) begin
      errors++; $display("FAIL rst_wr_bus: got %h expected 000", {wr_addr_o, wr_data_o});
    end
    rst_i = 1'b0;
    hq();
  endtask

  task automatic test_write_basic();
    wq = '{8'hA5, 8'h5A};
    do_write(8'h03);
  endtask

  task automatic test_read_repeated();
    do_read(8'h03, 2, 1'b1);
  endtask

  task automatic test_wrap();
    int s0;
    s0 = strobe_n;
    wq = '{8'h11, 8'h22};
    do_write(8'h0F);
    checks++;
    if (strobe_log[s0] !== 12'hF11 || strobe_log[s0 + 1] !== 12'h022) begin
      errors++; $display("FAIL wrap_strobes: got %h %h expected f11 022", strobe_log[s0], strobe_log[s0 + 1]);
    end
    do_read(8'h00, 1, 1'b1);
  endtask

  task automatic test_wrong_addr();
    logic a, a2;
    int   lo0, b0, s0;
    lo0 = sda_low_n; b0 = busy_n; s0 = strobe_n;
    i2c_start();
    send_byte({7'h23, 1'b0}, a);
    send_byte(8'h01, a2);
    i2c_stop();
    checks++;
    if (a !== 1'b1 || a2 !== 1'b1) begin errors++; $display("FAIL bad_addr_nack: got %b%b expected 11", a, a2); end
    checks++;
    if (sda_low_n != lo0) begin errors++; $display("FAIL bad_addr_sda: got %0d low cycles expected 0", sda_low_n - lo0); end
    checks++;
    if (busy_n != b0) begin errors++; $display("FAIL bad_addr_busy: got %0d busy cycles expected 0", busy_n - b0); end
    checks++;
    if (strobe_n != s0) begin errors++; $display("FAIL bad_addr_strobe: got %0d expected 0", strobe_n - s0); end
  endtask

  task automatic test_partial_stop();
    logic a;
    int   s0;
    wq = '{8'h66};
    do_write(8'h06);
    s0 = strobe_n;
    i2c_start();
    send_byte({SADDR, 1'b0}, a);
    send_byte(8'h06, a);
    model_ptr = 6;
    send_bits(4, 8'hE0);
    i2c_stop();
    checks++;
    if (strobe_n != s0) begin errors++; $display("FAIL partial_strobe: got %0d expected 0", strobe_n - s0); end
    do_read(8'h00, 1, 1'b0);
  endtask

  task automatic test_random();
    int n;
    for (int it = 0; it < 12; it++) begin
      wq = {};
      n = $urandom_range(1, 4);
      for (int k = 0; k < n; k++) wq.push_back(8'($urandom));
      do_write(8'($urandom_range(0, 255)));
      do_read(8'($urandom_range(0, 255)), $urandom_range(1, 5), 1'b1);
    end
  endtask

  task automatic test_reset_mid_ack();
    i2c_start();
    send_bits(8, {SADDR, 1'b0});
    hq();
    checks++;
    if (sda_o !== 1'b0) begin errors++; $display("FAIL mid_ack_driven: got %b expected 0", sda_o); end
    rst_i = 1'b1;
    #1;
    checks++;
    if (sda_o !== 1'b1) begin errors++; $display("FAIL mid_ack_async_release: got %b expected 1", sda_o); end
    checks++;
    if (busy_o !== 1'b0) begin errors++; $display("FAIL mid_ack_busy: got %b expected 0", busy_o); end
    repeat (3) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
    model_ptr = 0;
    i2c_stop();
    do_read(8'h00, DEPTH, 1'b1);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
    test_reset();
    test_write_basic();
    test_read_repeated();
    test_wrap();
    test_wrong_addr();
    test_partial_stop();
    test_random();
    test_reset_mid_ack();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
